hbm_cattrip_ctrl: RTL and testbench

//  Produces the board-level HBM_CATTRIP pin that the top-level aux wrapper forwards to the package pin.

---
 rtl/hbm_cattrip_pkg.sv | 27 ++
 rtl/hbm_cattrip_debounce.sv | 56 +++++
 rtl/hbm_cattrip_ctrl.sv | 137 +++++++++++++
 tb/tb_hbm_cattrip_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbm_cattrip_pkg.sv
// ---------------------------------------------------------------------------
// hbm_cattrip_pkg
// Shared definitions for the HBM catastrophic-trip controller:
//   - state_e      : controller FSM state (2-bit encoding)
//   - DEF_*        : default parameter values used by the top and sub-module
//   - holds_pin()  : true for the states in which HBM_CATTRIP must be high
// ---------------------------------------------------------------------------
package hbm_cattrip_pkg;

    localparam int DEF_NUM_STACKS      = 2;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_CNT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_TRIPPED  = 2'd2,
        ST_CLEARING = 2'd3
    } state_e;

    // The pin stays asserted until the clear handshake has fully completed.
    function automatic logic holds_pin(input state_e st);
        return (st == ST_TRIPPED) || (st == ST_CLEARING);
    endfunction

endpackage : hbm_cattrip_pkg

// File: rtl/hbm_cattrip_debounce.sv
// ---------------------------------------------------------------------------
// hbm_cattrip_debounce
// One stack's trip flag: synchronizer chain followed by a saturating
// run-length counter of consecutive synced-high cycles.
// Ports:
//   ap_clk    in  clock
//   ap_rst_n  in  asynchronous active-low reset
//   raw_i     in  raw trip flag, asynchronous to ap_clk
//   s_o       out synchronized flag
//   q_o       out qualified: flag has been synced-high DEBOUNCE_CYCLES cycles
// ---------------------------------------------------------------------------
module hbm_cattrip_debounce
    import hbm_cattrip_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic raw_i,
    output logic s_o,
    output logic q_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q  <= cnt_d;
        end
    end

    assign s_o = sync_q[SYNC_STAGES-1];

    // Any synced-low cycle restarts the qualification window.
    always_comb begin
        cnt_d = cnt_q;
        if (!s_o) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign q_o = (cnt_q == CNT_MAX);

endmodule : hbm_cattrip_debounce

// File: rtl/hbm_cattrip_ctrl.sv
// ---------------------------------------------------------------------------
// hbm_cattrip_ctrl
// Drives the board-level HBM_CATTRIP pin from per-stack raw trip flags.
// Each flag is synchronized and debounced; a qualified trip latches the pin
// until the host completes a clear handshake with all flags low.
// Optional feature macro: HBM_CATTRIP_FORCE_EN adds input force_trip, which
// trips immediately from IDLE/DEBOUNCE and blocks clears while high.
// Ports:
//   ap_clk        in  clock
//   ap_rst_n      in  asynchronous active-low reset
//   hbm_trip_raw  in  [NUM_STACKS] raw trip flags (asynchronous)
//   clr_req       in  host clear request, level held until clr_ack
//   force_trip    in  (HBM_CATTRIP_FORCE_EN only) synchronous forced trip
//   clr_ack       out one-cycle pulse when a clear completes
//   HBM_CATTRIP   out registered active-high trip pin
//   trip_src      out [NUM_STACKS] sticky mask of qualifying stacks
//   trip_count    out [CNT_W] saturating count of trip entries
// ---------------------------------------------------------------------------
module hbm_cattrip_ctrl
    import hbm_cattrip_pkg::*;
#(
    parameter int NUM_STACKS      = DEF_NUM_STACKS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [NUM_STACKS-1:0] hbm_trip_raw,
    input  logic                  clr_req,
`ifdef HBM_CATTRIP_FORCE_EN
    input  logic                  force_trip,
`endif
    output logic                  clr_ack,
    output logic                  HBM_CATTRIP,
    output logic [NUM_STACKS-1:0] trip_src,
    output logic [CNT_W-1:0]      trip_count
);

    logic [NUM_STACKS-1:0] s_w;
    logic [NUM_STACKS-1:0] q_w;
    logic                  s_any;
    logic                  q_any;
    logic                  force_w;

    state_e                state_q, state_d;
    logic                  cattrip_q, cattrip_d;
    logic                  ack_q, ack_d;
    logic [NUM_STACKS-1:0] src_q, src_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  enter_trip;

    for (genvar gi = 0; gi < NUM_STACKS; gi++) begin : g_stack
        hbm_cattrip_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .raw_i    (hbm_trip_raw[gi]),
            .s_o      (s_w[gi]),
            .q_o      (q_w[gi])
        );
    end

`ifdef HBM_CATTRIP_FORCE_EN
    assign force_w = force_trip;
`else
    assign force_w = 1'b0;
`endif

    assign s_any = |s_w;
    assign q_any = |q_w;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= ST_IDLE;
            cattrip_q <= 1'b0;
            ack_q     <= 1'b0;
            src_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cattrip_q <= cattrip_d;
            ack_q     <= ack_d;
            src_q     <= src_d;
            count_q   <= count_d;
        end
    end

    // Next-state: a trip (or any synced flag) always beats a pending clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (force_w)    state_d = ST_TRIPPED;
                else if (s_any) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (q_any || force_w) state_d = ST_TRIPPED;
                else if (!s_any)      state_d = ST_IDLE;
            end
            ST_TRIPPED: begin
                if (clr_req && !s_any && !force_w) state_d = ST_CLEARING;
            end
            ST_CLEARING: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs and sticky status.
    always_comb begin
        src_d      = src_q;
        count_d    = count_q;
        enter_trip = (state_d == ST_TRIPPED) && (state_q != ST_TRIPPED);
        cattrip_d  = holds_pin(state_d);
        ack_d      = (state_q == ST_CLEARING);

        if (enter_trip && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end

        // Only debounce-qualified stacks are recorded; a forced trip from
        // IDLE leaves the mask untouched.
        if (state_q == ST_CLEARING) begin
            src_d = '0;
        end else if ((state_q == ST_TRIPPED) || ((state_q == ST_DEBOUNCE) && q_any)) begin
            src_d = src_q | q_w;
        end
    end

    assign HBM_CATTRIP = cattrip_q;
    assign clr_ack     = ack_q;
    assign trip_src    = src_q;
    assign trip_count  = count_q;

endmodule : hbm_cattrip_ctrl

// File: tb/tb_hbm_cattrip_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hbm_cattrip_ctrl
// Directed bench for hbm_cattrip_ctrl with a cycle-level reference model.
// Build with +define+HBM_CATTRIP_FORCE_EN to also cover the forced trip.
// ---------------------------------------------------------------------------
module tb_hbm_cattrip_ctrl;

    localparam int NS     = 2;
    localparam int SS     = 2;
    localparam int DC     = 16;
    localparam int CW     = 8;
    localparam int CNTMAX = (1 << CW) - 1;

    localparam int MD_IDLE = 0;
    localparam int MD_DEB  = 1;
    localparam int MD_TRIP = 2;
    localparam int MD_CLR  = 3;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [NS-1:0] hbm_trip_raw = '0;
    logic          clr_req    = 1'b0;
    logic          force_trip = 1'b0;
    logic          clr_ack;
    logic          HBM_CATTRIP;
    logic [NS-1:0] trip_src;
    logic [CW-1:0] trip_count;

    int n_checks = 0;
    int n_fail   = 0;

    hbm_cattrip_ctrl #(
        .NUM_STACKS      (NS),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .hbm_trip_raw (hbm_trip_raw),
        .clr_req      (clr_req),
`ifdef HBM_CATTRIP_FORCE_EN
        .force_trip   (force_trip),
`endif
        .clr_ack      (clr_ack),
        .HBM_CATTRIP  (HBM_CATTRIP),
        .trip_src     (trip_src),
        .trip_count   (trip_count)
    );

    always #5 ap_clk = ~ap_clk;

    // ---------------- reference model ----------------
    // raw_seen[i][k] = raw value sampled k+1 edges ago; the synced flag is the
    // sample taken SS edges back. run[i] = length of the current synced-high run.
    logic [SS-1:0] raw_seen [NS];
    int            run [NS];
    int            m_mode;
    int            m_next;
    logic          m_cattrip;
    logic          m_ack;
    logic [NS-1:0] m_src;
    int            m_count;
    logic [NS-1:0] m_s;
    logic [NS-1:0] m_q;

    always_comb begin
        m_s = '0;
        m_q = '0;
        for (int i = 0; i < NS; i++) begin
            m_s[i] = raw_seen[i][SS-1];
            m_q[i] = (run[i] >= DC);
        end
    end

    function automatic int next_mode(input int md, input logic s_any, input logic q_any,
                                     input logic clr, input logic frc);
        if (md == MD_IDLE) return frc ? MD_TRIP : (s_any ? MD_DEB : MD_IDLE);
        if (md == MD_DEB)  return (q_any || frc) ? MD_TRIP : (s_any ? MD_DEB : MD_IDLE);
        if (md == MD_TRIP) return (clr && !s_any && !frc) ? MD_CLR : MD_TRIP;
        return MD_IDLE;
    endfunction

    always_comb m_next = next_mode(m_mode, |m_s, |m_q, clr_req, force_trip);

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_mode    <= MD_IDLE;
            m_cattrip <= 1'b0;
            m_ack     <= 1'b0;
            m_src     <= '0;
            m_count   <= 0;
            for (int i = 0; i < NS; i++) begin
                raw_seen[i] <= '0;
                run[i]      <= 0;
            end
        end else begin
            m_mode    <= m_next;
            m_cattrip <= (m_next == MD_TRIP) || (m_next == MD_CLR);
            m_ack     <= (m_mode == MD_CLR);
            if (m_next == MD_TRIP && m_mode != MD_TRIP)
                m_count <= (m_count >= CNTMAX) ? CNTMAX : m_count + 1;
            if (m_mode == MD_CLR)
                m_src <= '0;
            else if (m_mode == MD_TRIP || (m_mode == MD_DEB && (|m_q)))
                m_src <= m_src | m_q;
            for (int i = 0; i < NS; i++) begin
                raw_seen[i] <= {raw_seen[i][SS-2:0], hbm_trip_raw[i]};
                run[i]      <= m_s[i] ? ((run[i] >= DC) ? DC : run[i] + 1) : 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ap_clk) begin
        chk("model_cattrip", 32'(HBM_CATTRIP), 32'(m_cattrip));
        chk("model_ack",     32'(clr_ack),     32'(m_ack));
        chk("model_src",     32'(trip_src),    32'(m_src));
        chk("model_count",   32'(trip_count),  32'(m_count));
    end

    task automatic step(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_cattrip(input logic lvl, input int budget);
        int k = 0;
        while (HBM_CATTRIP !== lvl && k < budget) begin
            step(1);
            k++;
        end
        chk("wait_cattrip", 32'(HBM_CATTRIP), 32'(lvl));
    endtask

    task automatic wait_ack(input int budget);
        int k = 0;
        while (clr_ack !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        chk("wait_ack", 32'(clr_ack), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        chk("rst_cattrip", 32'(HBM_CATTRIP), 32'd0);
        chk("rst_count",   32'(trip_count),  32'd0);
        chk("rst_src",     32'(trip_src),    32'd0);
        ap_rst_n     = 1'b1;
        hbm_trip_raw = 2'b01;

        // 1: held trip qualifies at edge 19
        step(18);
        chk("t1_edge18_low", 32'(HBM_CATTRIP), 32'd0);
        step(1);
        chk("t1_edge19_high", 32'(HBM_CATTRIP), 32'd1);
        chk("t1_src",   32'(trip_src),   32'd1);
        chk("t1_count", 32'(trip_count), 32'd1);
        $display("txn t1 held trip: cattrip=%0b src=%b count=%0d", HBM_CATTRIP, trip_src, trip_count);

        // 3: clear ignored while raw high, completes 3 edges after raw drop is sampled
        clr_req = 1'b1;
        step(6);
        chk("t3_no_ack", 32'(clr_ack), 32'd0);
        hbm_trip_raw = 2'b00;
        step(3);
        chk("t3_clearing_pin", 32'(HBM_CATTRIP), 32'd1);
        chk("t3_clearing_ack", 32'(clr_ack),     32'd0);
        step(1);
        chk("t3_ack",     32'(clr_ack),     32'd1);
        chk("t3_pin_low", 32'(HBM_CATTRIP), 32'd0);
        chk("t3_src",     32'(trip_src),    32'd0);
        clr_req = 1'b0;
        step(1);
        chk("t3_ack_pulse", 32'(clr_ack), 32'd0);
        $display("txn t3 clear handshake: pin=%0b src=%b", HBM_CATTRIP, trip_src);

        // 2: 10-cycle glitch on stack 1
        hbm_trip_raw = 2'b10;
        step(10);
        hbm_trip_raw = 2'b00;
        step(20);
        chk("t2_pin",   32'(HBM_CATTRIP), 32'd0);
        chk("t2_src",   32'(trip_src),    32'd0);
        chk("t2_count", 32'(trip_count),  32'd1);
        $display("txn t2 glitch: pin=%0b count=%0d", HBM_CATTRIP, trip_count);

        // Trip wins: stack 0 hands over to stack 1 with no all-low gap
        hbm_trip_raw = 2'b01;
        wait_cattrip(1'b1, 40);
        clr_req      = 1'b1;
        hbm_trip_raw = 2'b10;
        step(30);
        chk("tw_pin",   32'(HBM_CATTRIP), 32'd1);
        chk("tw_src",   32'(trip_src),    32'd3);
        chk("tw_count", 32'(trip_count),  32'd2);
        hbm_trip_raw = 2'b00;
        wait_ack(20);
        chk("tw_src_clr", 32'(trip_src), 32'd0);
        clr_req = 1'b0;
        $display("txn handover: count=%0d", trip_count);

        // Flag returns during CLEARING: ack still issued, then re-trip
        hbm_trip_raw = 2'b01;
        wait_cattrip(1'b1, 40);
        clr_req      = 1'b1;
        hbm_trip_raw = 2'b00;
        step(1);
        hbm_trip_raw = 2'b01;
        wait_ack(20);
        clr_req = 1'b0;
        wait_cattrip(1'b1, 40);
        chk("rc_count", 32'(trip_count), 32'd4);
        clr_req      = 1'b1;
        hbm_trip_raw = 2'b00;
        wait_ack(20);
        clr_req = 1'b0;
        $display("txn retrip in clearing: count=%0d", trip_count);

        // 5: saturation
        for (int n = 0; n < 300; n++) begin
            hbm_trip_raw = 2'b01;
            wait_cattrip(1'b1, 40);
            clr_req      = 1'b1;
            hbm_trip_raw = 2'b00;
            wait_ack(20);
            clr_req = 1'b0;
        end
        chk("t5_sat", 32'(trip_count), 32'd255);
        $display("txn t5 saturation: count=%0d", trip_count);

        // 4: asynchronous reset mid-trip
        hbm_trip_raw = 2'b01;
        wait_cattrip(1'b1, 40);
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk("t4_pin",   32'(HBM_CATTRIP), 32'd0);
        chk("t4_count", 32'(trip_count),  32'd0);
        chk("t4_src",   32'(trip_src),    32'd0);
        $display("txn t4 async reset: pin=%0b count=%0d", HBM_CATTRIP, trip_count);
        hbm_trip_raw = 2'b00;
        step(2);
        ap_rst_n = 1'b1;
        step(3);

`ifdef HBM_CATTRIP_FORCE_EN
        // 6: forced trip bypasses debounce
        force_trip = 1'b1;
        step(1);
        force_trip = 1'b0;
        chk("t6_pin",   32'(HBM_CATTRIP), 32'd1);
        chk("t6_src",   32'(trip_src),    32'd0);
        chk("t6_count", 32'(trip_count),  32'd1);
        clr_req = 1'b1;
        wait_ack(10);
        clr_req = 1'b0;
        $display("txn t6 force: count=%0d", trip_count);
`endif

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hbm_cattrip_ctrl
